// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the mode-0 SPI master.
// Holds the transfer FSM encoding and the effective-length clamp.
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER_LO = 2'd1,
        XFER_HI = 2'd2
    } state_t;

    // Effective transfer length: requested size clamped to the register width.
    function automatic int unsigned eff_len(input int unsigned size, input int unsigned width);
        return (size > width) ? width : size;
    endfunction

endpackage

// File: rtl/spi_master.sv
// Single-channel SPI master, mode 0, fixed divide-by-2 SPI clock.
// Sends the low N bits of d_in MSB-first and returns the N captured bits right-aligned.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int reg_width     = 8,
    parameter int counter_width = $clog2(reg_width)
) (
    input  logic                   sys_clk,
    input  logic                   rstn,
    input  logic                   t_start,
    input  logic [reg_width-1:0]   d_in,
    input  logic [counter_width:0] t_size,
    output logic [reg_width-1:0]   d_out,
    input  logic                   miso,
    output logic                   mosi,
    output logic                   spi_clk,
    output logic                   cs
);

    localparam int CW = counter_width + 1;

    state_t                 state_reg;
    logic [reg_width-1:0]   tx_reg;
    logic [reg_width-1:0]   rx_reg;
    logic [reg_width-1:0]   d_out_reg;
    logic [counter_width:0] len_reg;
    logic [counter_width:0] cnt_reg;
    logic                   mosi_reg;
    logic                   spi_clk_reg;
    logic                   cs_reg;

    logic [counter_width:0] n_eff;
    logic [counter_width:0] shamt;
    logic [reg_width-1:0]   tx_load;
    logic [reg_width-1:0]   tx_shift;
    logic [reg_width-1:0]   rx_shift;
    logic                   last_bit;

    assign n_eff    = CW'(eff_len(32'(t_size), 32'(reg_width)));
    assign shamt    = CW'(reg_width) - n_eff;
    // Left-justify the low N bits so the TX MSB is always the bit on the wire.
    assign tx_load  = d_in << shamt;
    assign tx_shift = tx_reg << 1;
    assign rx_shift = (rx_reg << 1) | reg_width'(miso);
    assign last_bit = (cnt_reg == len_reg - 1'b1);

    always_ff @(posedge sys_clk) begin
        if (rstn) begin
            state_reg   <= IDLE;
            cs_reg      <= 1'b1;
            spi_clk_reg <= 1'b0;
            mosi_reg    <= 1'b0;
            d_out_reg   <= '0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            len_reg     <= '0;
            cnt_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (t_start && (t_size != '0)) begin
                        len_reg   <= n_eff;
                        tx_reg    <= tx_load;
                        mosi_reg  <= tx_load[reg_width-1];
                        rx_reg    <= '0;
                        cnt_reg   <= '0;
                        cs_reg    <= 1'b0;
                        state_reg <= XFER_LO;
                    end
                end
                XFER_LO: begin
                    spi_clk_reg <= 1'b1;
                    rx_reg      <= rx_shift;
                    state_reg   <= XFER_HI;
                end
                XFER_HI: begin
                    spi_clk_reg <= 1'b0;
                    if (last_bit) begin
                        cs_reg    <= 1'b1;
                        mosi_reg  <= 1'b0;
                        // RX was cleared at start, so N shifts leave it right-aligned and zero-extended.
                        d_out_reg <= rx_reg;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                        tx_reg    <= tx_shift;
                        mosi_reg  <= tx_shift[reg_width-1];
                        state_reg <= XFER_LO;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign d_out   = d_out_reg;
    assign mosi    = mosi_reg;
    assign spi_clk = spi_clk_reg;
    assign cs      = cs_reg;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected windows,
// a monitor closes each cs-low window and compares it against the queue head.
module tb_spi_master;

    logic       sys_clk;
    logic       rstn;
    logic       t_start;
    logic [7:0] d_in;
    logic [3:0] t_size;
    logic [7:0] d_out;
    logic       miso;
    logic       mosi;
    logic       spi_clk;
    logic       cs;

    logic       loop_en;
    logic       miso_val;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] dout;
        int         cycles;
        int         pulses;
        logic [7:0] bits;
        bit         abort;
    } exp_t;

    exp_t exp_q[$];

    assign miso = loop_en ? mosi : miso_val;

    spi_master dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .t_start (t_start),
        .d_in    (d_in),
        .t_size  (t_size),
        .d_out   (d_out),
        .miso    (miso),
        .mosi    (mosi),
        .spi_clk (spi_clk),
        .cs      (cs)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: tracks each cs-low window and checks it when cs rises.
    logic       prev_cs;
    logic       prev_clk;
    int         low_cnt;
    int         pulse_cnt;
    logic [7:0] mosi_bits;

    initial begin
        exp_t e;
        prev_cs   = 1'b1;
        prev_clk  = 1'b0;
        low_cnt   = 0;
        pulse_cnt = 0;
        mosi_bits = '0;
        forever begin
            @(negedge sys_clk);
            if (cs === 1'b0) begin
                if (prev_cs === 1'b1) begin
                    low_cnt   = 0;
                    pulse_cnt = 0;
                    mosi_bits = '0;
                end
                low_cnt++;
                if (spi_clk === 1'b1 && prev_clk !== 1'b1) begin
                    pulse_cnt++;
                    mosi_bits = {mosi_bits[6:0], mosi};
                end
            end else if (prev_cs === 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_window: got cs window of %0d cycles, required none", low_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.abort) begin
                        if (d_out !== 8'h00) begin
                            errors++;
                            $display("FAIL abort_dout: got %02h required 00", d_out);
                        end
                    end else begin
                        if (d_out !== e.dout) begin
                            errors++;
                            $display("FAIL dout: got %02h required %02h", d_out, e.dout);
                        end
                        checks++;
                        if (low_cnt != e.cycles) begin
                            errors++;
                            $display("FAIL cs_low_cycles: got %0d required %0d", low_cnt, e.cycles);
                        end
                        checks++;
                        if (pulse_cnt != e.pulses) begin
                            errors++;
                            $display("FAIL spi_clk_pulses: got %0d required %0d", pulse_cnt, e.pulses);
                        end
                        checks++;
                        if (mosi_bits !== e.bits) begin
                            errors++;
                            $display("FAIL mosi_bits: got %02h required %02h", mosi_bits, e.bits);
                        end
                    end
                    $display("window: cycles=%0d pulses=%0d mosi=%02h d_out=%02h abort=%0d",
                             low_cnt, pulse_cnt, mosi_bits, d_out, e.abort);
                end
            end
            prev_cs  = cs;
            prev_clk = spi_clk;
        end
    end

    task automatic push_exp(input logic [7:0] dout, input int cycles, input int pulses,
                            input logic [7:0] bits, input bit abort);
        exp_t e;
        e.dout   = dout;
        e.cycles = cycles;
        e.pulses = pulses;
        e.bits   = bits;
        e.abort  = abort;
        exp_q.push_back(e);
    endtask

    // Issue a one-cycle t_start; returns at the negedge after the sampling edge.
    task automatic start(input logic [7:0] d, input logic [3:0] sz);
        @(negedge sys_clk);
        t_start = 1'b1;
        d_in    = d;
        t_size  = sz;
        @(negedge sys_clk);
        t_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (cs !== 1'b1 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (cs !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: cs got %b required 1 within 200 cycles", name, cs);
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %02h required %02h", name, got, req);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rstn     = 1'b1;
        t_start  = 1'b0;
        d_in     = '0;
        t_size   = '0;
        loop_en  = 1'b1;
        miso_val = 1'b0;
        repeat (3) @(negedge sys_clk);
        rstn = 1'b0;
        @(negedge sys_clk);

        check_bit("reset_cs", cs, 1'b1);
        check_bit("reset_spi_clk", spi_clk, 1'b0);
        check_bit("reset_mosi", mosi, 1'b0);
        check_byte("reset_dout", d_out, 8'h00);
        $display("reset: cs=%b spi_clk=%b mosi=%b d_out=%02h", cs, spi_clk, mosi, d_out);

        // Loopback 0x55, 8 bits.
        push_exp(8'h55, 16, 8, 8'h55, 1'b0);
        start(8'h55, 4'd8);
        wait_done("loop55");

        // Busy rejection: a second start six cycles in must be ignored.
        push_exp(8'h55, 16, 8, 8'h55, 1'b0);
        start(8'h55, 4'd8);
        repeat (5) @(negedge sys_clk);
        t_start = 1'b1;
        d_in    = 8'hAA;
        t_size  = 4'd8;
        @(negedge sys_clk);
        t_start = 1'b0;
        wait_done("busy");
        repeat (3) @(negedge sys_clk);
        check_bit("busy_no_second_window", cs, 1'b1);

        push_exp(8'hAA, 16, 8, 8'hAA, 1'b0);
        start(8'hAA, 4'd8);
        wait_done("loopAA");

        // Short transfer: low 4 bits of 0xA5.
        push_exp(8'h05, 8, 4, 8'h05, 1'b0);
        start(8'hA5, 4'd4);
        wait_done("short");

        // Reset on cycle 5 of an 8-bit transfer.
        push_exp(8'h00, 0, 0, 8'h00, 1'b1);
        start(8'h55, 4'd8);
        repeat (3) @(negedge sys_clk);
        rstn = 1'b1;
        @(negedge sys_clk);
        rstn = 1'b0;
        check_bit("abort_cs", cs, 1'b1);
        check_bit("abort_spi_clk", spi_clk, 1'b0);
        check_bit("abort_mosi", mosi, 1'b0);
        check_byte("abort_dout_now", d_out, 8'h00);
        $display("abort: cs=%b spi_clk=%b mosi=%b d_out=%02h", cs, spi_clk, mosi, d_out);
        repeat (2) @(negedge sys_clk);

        // miso held high, 3 bits of zero.
        loop_en  = 1'b0;
        miso_val = 1'b1;
        push_exp(8'h07, 6, 3, 8'h00, 1'b0);
        start(8'h00, 4'd3);
        wait_done("miso_high");

        // t_size = 0 must be ignored entirely.
        start(8'hFF, 4'd0);
        repeat (4) begin
            check_bit("zero_size_cs", cs, 1'b1);
            check_bit("zero_size_spi_clk", spi_clk, 1'b0);
            @(negedge sys_clk);
        end
        check_byte("zero_size_dout", d_out, 8'h07);
        $display("zero_size: cs=%b spi_clk=%b d_out=%02h", cs, spi_clk, d_out);

        // t_size = 12 clamps to 8 bits.
        miso_val = 1'b0;
        push_exp(8'h00, 16, 8, 8'hC3, 1'b0);
        start(8'hC3, 4'd12);
        wait_done("clamp");

        repeat (5) @(negedge sys_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_windows: got %0d outstanding required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Single-channel SPI master (mode 0: CPOL=0, CPHA=0) that serialises a variable-length word of 1..reg_width bits MSB-first on mosi while capturing miso, then presents the received word on d_out. It sits between a register-level host interface (start pulse plus parallel data) and one external SPI slave, with a single chip-select. The SPI clock is derived from the system clock at a fixed divide-by-2.

## Interface
- reg_width, default 8: maximum transfer length in bits; width of d_in/d_out.
- counter_width, default $clog2(reg_width): t_size is counter_width+1 bits so that the value reg_width is representable.

- sys_clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  reset; synchronous, active-high (asserted = 1), despite the name.
- t_start  input  1  one-cycle start request; sampled only in IDLE.
- d_in  input  reg_width  transmit word; the low t_size bits are sent.
- t_size  input  counter_width+1  transfer length in bits.
- d_out  output  reg_width  last received word, right-aligned and zero-extended.
- miso  input  1  serial data from the slave.
- mosi  output  1  serial data to the slave.
- spi_clk  output  1  SPI clock, idle low.
- cs  output  1  chip select, active low, idle high.

## Operation
- States: IDLE, XFER_LO (spi_clk low, mosi stable), XFER_HI (spi_clk high).
- IDLE: cs=1, spi_clk=0, mosi=0.
- IDLE with t_start=1 and t_size≠0: latch the effective length N = min(t_size, reg_width) and left-justify d_in[N-1:0] into the TX shift register. Clear the RX shift register and bit counter. Drive cs=0 and mosi=d_in[N-1]. Go to XFER_LO.
- IDLE with t_start=1 and t_size=0: ignored. Stay in IDLE with no output change.
- XFER_LO → XFER_HI: drive spi_clk=1 and shift miso into the RX register LSB.
- XFER_HI, bits remaining: drive spi_clk=0, present the next TX bit on mosi, increment the bit counter, go to XFER_LO.
- XFER_HI, last bit: drive spi_clk=0, cs=1, mosi=0. Load d_out with the N received bits zero-extended. Return to IDLE.
- t_start while not in IDLE is ignored. d_in and t_size are not re-sampled mid-transfer.
- d_out holds its value until the next completed transfer. An aborted transfer never updates it.

## Timing
- Reset values: cs=1, spi_clk=0, mosi=0, d_out=0, state IDLE.
- Reset asserted mid-transfer aborts immediately on the next edge, with all outputs at their reset values.
- t_start sampled at edge E0 → cs falls and the first mosi bit appears at E0.
- spi_clk rises at E1, E3, …, E(2N-1), and miso is sampled at those same edges.
- spi_clk falls at E2, E4, …; the transfer ends at E(2N), where cs rises and d_out is updated.
- cs is low for exactly 2N sys_clk cycles. spi_clk period = 2 sys_clk cycles at 50% duty.
- A new t_start is accepted from E(2N) onward, so back-to-back transfers have zero idle cycles.
- mosi changes only on spi_clk falling edges or at cs assertion, giving a half-period of setup before each rising edge.

## Structure
- Shared package spi_master_pkg holds:
  - the state enum (IDLE, XFER_LO, XFER_HI);
  - the helper function computing N = min(t_size, reg_width).
- A single top module is sufficient. An optional sub-module, spi_shift_reg, is natural for the parameterised TX/RX shift pair (load, shift, right-align on completion).

## Test plan
- Loopback (miso tied to mosi), d_in=0x55, t_size=8, one-cycle t_start → mosi sequence 0,1,0,1,0,1,0,1 on the 8 rising edges. cs low for 16 cycles, then d_out=0x55.
- Busy rejection: start 0x55/8 bits, pulse t_start again 6 cycles later with d_in=0xAA → the second pulse is ignored, only one 16-cycle cs window occurs, and d_out=0x55. A t_start after cs rises with 0xAA → d_out=0xAA.
- Short transfer: loopback, d_in=0xA5, t_size=4 → 4 spi_clk pulses, mosi 0,1,0,1, cs low for 8 cycles, d_out=0x05.
- miso tied 1, t_size=3, d_in=0x00 → mosi stays 0, d_out=0x07. Then t_size=12 (clamped) with miso=0 → 8 bits transferred, d_out=0x00.
- t_size=0 with t_start → cs stays 1, spi_clk stays 0, d_out unchanged.
- Reset asserted on cycle 5 of an 8-bit transfer → next edge gives cs=1, spi_clk=0, mosi=0, d_out=0. A new transfer after reset completes normally.
